// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: memory op codes,
// LSU FSM states, stall levels and the zero word.
package mem_lsu_pkg;

  typedef enum logic [3:0] {
    MEM_OP_NONE = 4'd0,
    MEM_OP_LB   = 4'd1,
    MEM_OP_LBU  = 4'd2,
    MEM_OP_LH   = 4'd3,
    MEM_OP_LHU  = 4'd4,
    MEM_OP_LW   = 4'd5,
    MEM_OP_SB   = 4'd6,
    MEM_OP_SH   = 4'd7,
    MEM_OP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_HOLD
  } lsu_state_e;

  localparam logic        Stop     = 1'b1;
  localparam logic        NoStop   = 1'b0;
  localparam logic [31:0] ZeroWord = '0;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op >= MEM_OP_LB) && (op <= MEM_OP_LW);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op >= MEM_OP_SB) && (op <= MEM_OP_SW);
  endfunction

endpackage

// File: rtl/mem_lsu_lane_align.sv
// Big-endian lane mapping shared by both directions: byte-select and
// replicated write data for stores, lane extract and sign/zero extend for loads.
module mem_lane_align
  import mem_lsu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  sel,
  output logic [31:0] st_wdata,
  output logic [31:0] ld_data
);

  logic [7:0]  lbyte;
  logic [15:0] lhalf;

  always_comb begin
    sel      = '0;
    st_wdata = ZeroWord;
    ld_data  = ZeroWord;

    // Byte 0 of the word lives in bits [31:24].
    case (addr_lo)
      2'd0:    lbyte = ld_word[31:24];
      2'd1:    lbyte = ld_word[23:16];
      2'd2:    lbyte = ld_word[15:8];
      default: lbyte = ld_word[7:0];
    endcase
    lhalf = addr_lo[1] ? ld_word[15:0] : ld_word[31:16];

    case (op)
      MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: sel = 4'b1000 >> addr_lo;
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: sel = addr_lo[1] ? 4'b0011 : 4'b1100;
      MEM_OP_LW, MEM_OP_SW:             sel = '1;
      default:                          sel = '0;
    endcase

    case (op)
      MEM_OP_SB: st_wdata = {4{st_data[7:0]}};
      MEM_OP_SH: st_wdata = {2{st_data[15:0]}};
      MEM_OP_SW: st_wdata = st_data;
      default:   st_wdata = ZeroWord;
    endcase

    case (op)
      MEM_OP_LB:  ld_data = {{24{lbyte[7]}}, lbyte};
      MEM_OP_LBU: ld_data = {24'd0, lbyte};
      MEM_OP_LH:  ld_data = {{16{lhalf[15]}}, lhalf};
      MEM_OP_LHU: ld_data = {16'd0, lhalf};
      MEM_OP_LW:  ld_data = ld_word;
      default:    ld_data = ZeroWord;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: pass-through of non-memory results plus a
// single-outstanding data-bus transaction per load/store.
// Optional misalignment trap: define MEM_ALIGN_CHECK_EN.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic [4:0]        ex_wd,
  input  logic              ex_wreg,
  input  logic [31:0]       ex_wdata,
  input  logic [31:0]       ex_hi,
  input  logic [31:0]       ex_lo,
  input  logic              ex_whilo,
  input  logic [3:0]        ex_mem_op,
  input  logic [31:0]       ex_mem_addr,
  input  logic [31:0]       ex_reg2,
  output logic [4:0]        mem_wd,
  output logic              mem_wreg,
  output logic [31:0]       mem_wdata,
  output logic [31:0]       mem_hi,
  output logic [31:0]       mem_lo,
  output logic              mem_whilo,
  output logic              stallreq,
  output logic              bus_cyc_stb,
  output logic              bus_we,
  output logic [3:0]        bus_sel,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              addr_err
);

  lsu_state_e  state;
  logic [31:0] rdata_q;
  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        misalign;
  logic [3:0]  sel;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
  logic        unused_ok;

  assign unused_ok = ^{stall[5], stall[3:0]};

  assign is_load  = op_is_load(ex_mem_op);
  assign is_store = op_is_store(ex_mem_op);
  assign is_mem   = is_load | is_store;

  mem_lane_align u_align (
    .op       (ex_mem_op),
    .addr_lo  (ex_mem_addr[1:0]),
    .st_data  (ex_reg2),
    .ld_word  (bus_rdata),
    .sel      (sel),
    .st_wdata (st_wdata),
    .ld_data  (ld_data)
  );

`ifdef MEM_ALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    case (ex_mem_op)
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: misalign = ex_mem_addr[0];
      MEM_OP_LW, MEM_OP_SW:             misalign = |ex_mem_addr[1:0];
      default:                          misalign = 1'b0;
    endcase
  end
  assign addr_err = (state == ST_IDLE) && misalign;
`else
  assign misalign = 1'b0;
  assign addr_err = 1'b0;
`endif

  assign mem_wd    = ex_wd;
  assign mem_wreg  = ex_wreg & ~addr_err;
  assign mem_hi    = ex_hi;
  assign mem_lo    = ex_lo;
  assign mem_whilo = ex_whilo;

  always_comb begin
    stallreq  = 1'b0;
    mem_wdata = ex_wdata;
    case (state)
      ST_IDLE: stallreq = is_mem & ~misalign;
      ST_BUSY: stallreq = ~bus_ack;
      default: stallreq = 1'b0;
    endcase
    if (is_load) begin
      if (state == ST_BUSY && bus_ack)
        mem_wdata = ld_data;
      else if (state == ST_HOLD)
        mem_wdata = rdata_q;
      else
        mem_wdata = ZeroWord;
    end
  end

  // HOLD parks a completed access while MEM is held by someone else, so the
  // still-present instruction is never re-issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      bus_cyc_stb <= 1'b0;
      bus_we      <= 1'b0;
      bus_sel     <= '0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      rdata_q     <= ZeroWord;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_mem && !misalign) begin
            bus_cyc_stb <= 1'b1;
            bus_we      <= is_store;
            bus_sel     <= sel;
            bus_addr    <= {ex_mem_addr[ADDR_W-1:2], 2'b00};
            bus_wdata   <= st_wdata;
            state       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus_ack) begin
            bus_cyc_stb <= 1'b0;
            bus_we      <= 1'b0;
            rdata_q     <= ld_data;
            state       <= (stall[4] == Stop) ? ST_HOLD : ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (stall[4] == NoStop)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: directed loads/stores push expected bus
// transactions; a monitor pops and compares on every acked cycle.
module tb_mem_lsu;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic        ex_whilo;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_reg2;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_whilo;
  logic        stallreq;
  logic        bus_cyc_stb;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        addr_err;

  mem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .ex_wd       (ex_wd),
    .ex_wreg     (ex_wreg),
    .ex_wdata    (ex_wdata),
    .ex_hi       (ex_hi),
    .ex_lo       (ex_lo),
    .ex_whilo    (ex_whilo),
    .ex_mem_op   (ex_mem_op),
    .ex_mem_addr (ex_mem_addr),
    .ex_reg2     (ex_reg2),
    .mem_wd      (mem_wd),
    .mem_wreg    (mem_wreg),
    .mem_wdata   (mem_wdata),
    .mem_hi      (mem_hi),
    .mem_lo      (mem_lo),
    .mem_whilo   (mem_whilo),
    .stallreq    (stallreq),
    .bus_cyc_stb (bus_cyc_stb),
    .bus_we      (bus_we),
    .bus_sel     (bus_sel),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata),
    .addr_err    (addr_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] mwdata;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_txn    = 0;
  int unsigned ack_wait = 0;
  int unsigned ack_cnt  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: condition not reached within bound", name);
  endtask

  // Bus slave: ack after ack_wait un-acked BUSY cycles, one cycle wide.
  initial begin
    bus_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus_ack) begin
        bus_ack = 1'b0;
        ack_cnt = 0;
      end else if (bus_cyc_stb) begin
        if (ack_cnt >= ack_wait) bus_ack = 1'b1;
        else ack_cnt++;
      end else begin
        ack_cnt = 0;
      end
    end
  end

  // Monitor: every acked request cycle must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && bus_cyc_stb && bus_ack) begin
        n_txn++;
        if (sb.size() == 0) begin
          fail_now("sb_unexpected_txn");
        end else begin
          e = sb.pop_front();
          chk("txn_addr", bus_addr, e.addr);
          chk("txn_sel", {28'd0, bus_sel}, {28'd0, e.sel});
          chk("txn_we", {31'd0, bus_we}, {31'd0, e.we});
          if (e.we) chk("txn_wdata", bus_wdata, e.wdata);
          chk("txn_mem_wdata", mem_wdata, e.mwdata);
          chk("txn_stallreq_low", {31'd0, stallreq}, 32'd0);
        end
      end
    end
  end

  task automatic run_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                         input logic [31:0] alu, input logic [31:0] rdata, input int unsigned wait_n,
                         input logic [31:0] e_addr, input logic [3:0] e_sel, input logic [31:0] e_wdata,
                         input logic [31:0] e_mw, input bit ret_none);
    exp_t        e;
    int unsigned cnt;
    bit          done;
    e.addr = e_addr; e.sel = e_sel; e.we = (op >= 4'd6); e.wdata = e_wdata; e.mwdata = e_mw;
    sb.push_back(e);
    @(posedge clk);
    #1;
    ex_mem_op = op; ex_mem_addr = addr; ex_reg2 = reg2; ex_wdata = alu;
    bus_rdata = rdata; ack_wait = wait_n;
    cnt = 0; done = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!stallreq) begin
        done = 1;
        break;
      end
      cnt++;
    end
    if (!done) fail_now("stallreq_timeout");
    else chk("stall_cycles", cnt, wait_n + 1);
    #1;
    if (ret_none) begin
      @(posedge clk);
      #1;
      ex_mem_op = 4'd0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned t0;
    rst = 1'b0; stall = '0; ex_wd = '0; ex_wreg = 1'b0; ex_wdata = '0; ex_hi = '0; ex_lo = '0;
    ex_whilo = 1'b0; ex_mem_op = '0; ex_mem_addr = '0; ex_reg2 = '0; bus_rdata = '0;

    repeat (2) @(negedge clk);
    chk("rst_cyc_stb", {31'd0, bus_cyc_stb}, 32'd0);
    chk("rst_we", {31'd0, bus_we}, 32'd0);
    chk("rst_sel", {28'd0, bus_sel}, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_stallreq", {31'd0, stallreq}, 32'd0);
    chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Pass-through, op NONE
    @(posedge clk);
    #1;
    ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'h1234_5678; ex_hi = 32'hAAAA_0001;
    ex_lo = 32'h5555_0002; ex_whilo = 1'b1; ex_mem_op = 4'd0;
    @(negedge clk);
    chk("pt_wd", {27'd0, mem_wd}, 32'd3);
    chk("pt_wreg", {31'd0, mem_wreg}, 32'd1);
    chk("pt_wdata", mem_wdata, 32'h1234_5678);
    chk("pt_hi", mem_hi, 32'hAAAA_0001);
    chk("pt_lo", mem_lo, 32'h5555_0002);
    chk("pt_whilo", {31'd0, mem_whilo}, 32'd1);
    chk("pt_stallreq", {31'd0, stallreq}, 32'd0);
    @(negedge clk);
    chk("pt_no_bus", {31'd0, bus_cyc_stb}, 32'd0);

    // Unknown op behaves as NONE
    ex_mem_op = 4'hF;
    @(negedge clk);
    chk("badop_stallreq", {31'd0, stallreq}, 32'd0);
    chk("badop_wdata", mem_wdata, 32'h1234_5678);
    @(negedge clk);
    chk("badop_no_bus", {31'd0, bus_cyc_stb}, 32'd0);
    ex_mem_op = 4'd0;

    //      op     addr          reg2          alu           rdata         wait e_addr        sel      e_wdata       e_mw
    run_mem(4'd1, 32'h0000_0101, 32'h0,        32'h0,        32'h11F2_3344, 2, 32'h0000_0100, 4'b0100, 32'h0,        32'hFFFF_FFF2, 1);
    run_mem(4'd2, 32'h0000_0103, 32'h0,        32'h0,        32'h11F2_3344, 1, 32'h0000_0100, 4'b0001, 32'h0,        32'h0000_0044, 1);
    run_mem(4'd1, 32'h0000_0100, 32'h0,        32'h0,        32'h7F00_0000, 1, 32'h0000_0100, 4'b1000, 32'h0,        32'h0000_007F, 1);
    run_mem(4'd3, 32'h0000_0002, 32'h0,        32'h0,        32'h1234_8765, 0, 32'h0000_0000, 4'b0011, 32'h0,        32'hFFFF_8765, 1);
    run_mem(4'd4, 32'h0000_0000, 32'h0,        32'h0,        32'h8765_1234, 1, 32'h0000_0000, 4'b1100, 32'h0,        32'h0000_8765, 1);
    run_mem(4'd6, 32'h0000_0001, 32'h0000_00A5, 32'h1111_1111, 32'h0,      1, 32'h0000_0000, 4'b0100, 32'hA5A5_A5A5, 32'h1111_1111, 1);
    t0 = n_txn;
    run_mem(4'd7, 32'h0000_0202, 32'h0000_BEEF, 32'h0000_0202, 32'h0,      1, 32'h0000_0200, 4'b0011, 32'hBEEF_BEEF, 32'h0000_0202, 1);
    repeat (3) @(negedge clk);
    chk("sh_single_txn", n_txn - t0, 32'd1);
    run_mem(4'd8, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0010, 32'h0,      2, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0010, 1);

    // HOLD: MEM held by another requester across the ack
    t0 = n_txn;
    stall = 6'b011111;
    run_mem(4'd5, 32'h0000_0300, 32'h0, 32'h0, 32'hCAFE_F00D, 1, 32'h0000_0300, 4'b1111, 32'h0, 32'hCAFE_F00D, 0);
    @(posedge clk);
    #1 bus_rdata = 32'hDEAD_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_no_req", {31'd0, bus_cyc_stb}, 32'd0);
      chk("hold_stallreq", {31'd0, stallreq}, 32'd0);
      chk("hold_wdata", mem_wdata, 32'hCAFE_F00D);
    end
    @(posedge clk);
    #1 stall = '0;
    @(posedge clk);
    #1 ex_mem_op = 4'd0;
    repeat (3) @(negedge clk);
    chk("hold_single_txn", n_txn - t0, 32'd1);
    chk("hold_idle_no_req", {31'd0, bus_cyc_stb}, 32'd0);

    // Async reset in the middle of a transaction
    @(posedge clk);
    #1;
    ex_mem_op = 4'd5; ex_mem_addr = 32'h0000_0400; ack_wait = 10;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", {31'd0, bus_cyc_stb}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_cyc_stb", {31'd0, bus_cyc_stb}, 32'd0);
    chk("arst_addr", bus_addr, 32'd0);
    ex_mem_op = 4'd0;
    @(posedge clk);
    #1 rst = 1'b1;
    run_mem(4'd5, 32'h0000_0500, 32'h0, 32'h0, 32'h8000_0001, 1, 32'h0000_0500, 4'b1111, 32'h0, 32'h8000_0001, 1);

`ifdef MEM_ALIGN_CHECK_EN
    @(posedge clk);
    #1;
    ex_mem_op = 4'd5; ex_mem_addr = 32'h0000_0103; ex_wreg = 1'b1;
    @(negedge clk);
    chk("al_addr_err", {31'd0, addr_err}, 32'd1);
    chk("al_wreg", {31'd0, mem_wreg}, 32'd0);
    chk("al_stallreq", {31'd0, stallreq}, 32'd0);
    @(negedge clk);
    chk("al_no_bus", {31'd0, bus_cyc_stb}, 32'd0);
    ex_mem_op = 4'd7; ex_mem_addr = 32'h0000_0201;
    @(negedge clk);
    chk("al_sh_addr_err", {31'd0, addr_err}, 32'd1);
    ex_mem_op = 4'd0;
`else
    run_mem(4'd5, 32'h0000_0103, 32'h0, 32'h0, 32'h0102_0304, 1, 32'h0000_0100, 4'b1111, 32'h0, 32'h0102_0304, 1);
    @(negedge clk);
    chk("noal_addr_err", {31'd0, addr_err}, 32'd0);
`endif

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- MEM-stage load/store unit between the EX/MEM pipeline register and mem_wb.
- Passes non-memory results straight through.
- For loads and stores, runs a single-outstanding Wishbone-style data-bus transaction and asserts stallreq until the bus acks.
- Aligns and extends load data (big-endian) and drives the mem_* write-back bundle consumed by mem_wb.

Parameters:
- ADDR_W, 32, data-bus address width
- DATA_W, 32, data width; only 32 is supported

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low (rst==0 resets)
- stall  in  6  pipeline stall vector from ctrl; stall[4]=MEM hold, stall[5]=WB hold
- ex_wd  in  5  destination register address
- ex_wreg  in  1  register write enable
- ex_wdata  in  32  ALU result; used for non-memory ops
- ex_hi  in  32  HI value
- ex_lo  in  32  LO value
- ex_whilo  in  1  HI/LO write enable
- ex_mem_op  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; others treated as NONE
- ex_mem_addr  in  32  effective address
- ex_reg2  in  32  store data
- mem_wd  out  5  to mem_wb
- mem_wreg  out  1  to mem_wb
- mem_wdata  out  32  to mem_wb
- mem_hi  out  32  to mem_wb
- mem_lo  out  32  to mem_wb
- mem_whilo  out  1  to mem_wb
- stallreq  out  1  MEM-stage stall request to ctrl
- bus_cyc_stb  out  1  bus request
- bus_we  out  1  write strobe
- bus_sel  out  4  byte lanes; bit3=bits[31:24]
- bus_addr  out  ADDR_W  word-aligned address ({addr[31:2],2'b00})
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  transfer complete
- bus_rdata  in  32  read data
- addr_err  out  1  misaligned access flag (see Optional Feature)

Behaviour:
- Reset (async, rst==0): state=IDLE; bus_cyc_stb=0, bus_we=0, bus_sel=0, bus_addr=0, bus_wdata=0; rdata_q=0. Combinational outputs follow IDLE rules. A reset mid-BUSY drops bus_cyc_stb immediately; a pending ack is ignored.
- Pass-through: mem_wd, mem_wreg, mem_hi, mem_lo and mem_whilo always equal their ex_* inputs.
- mem_wdata:
  - ex_wdata for NONE and stores.
  - Load data for loads.
- Store lanes, big-endian:
  - SB: sel = 1000>>addr[1:0], data {4{b}}.
  - SH: sel = 1100 if addr[1]==0, else 0011; data {2{h}}.
  - SW: sel = 1111.
- Load extraction:
  - Same lane map as stores.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- FSM states IDLE, BUSY, HOLD:
  - IDLE, op NONE: stallreq=0, no bus activity.
  - IDLE, memory op: stallreq=1. Next edge registers bus_addr, bus_we, bus_sel and bus_wdata, sets bus_cyc_stb=1, and enters BUSY.
  - BUSY, bus_ack=0: stallreq=1, bus signals held.
  - BUSY, bus_ack=1: stallreq=0 in that cycle; mem_wdata comes from aligned bus_rdata. Next edge: bus_cyc_stb=0, rdata_q<=aligned data; go to HOLD if stall[4]==Stop, else IDLE.
  - HOLD: stallreq=0; mem_wdata=rdata_q; no re-issue. Return to IDLE on the edge where stall[4]==NoStop.
- Latency:
  - Non-memory op: 0 extra cycles.
  - Memory op: 1 issue cycle plus N wait cycles (N≥1 to ack); minimum 2 cycles in MEM.
- Exactly one transaction per instruction. stall[4] asserted by another requester never causes a duplicate bus access.
- bus_ack outside BUSY is ignored.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined:
  - LH/LHU/SH with addr[0]!=0, or LW/SW with addr[1:0]!=0, sets addr_err=1 combinationally in IDLE.
  - No bus transaction is issued; stallreq=0.
  - mem_wreg forced to 0.
- Undefined: addr_err tied 0; the address is used as-is (low bits ignored per lane map).

Decomposition:
- The shared defines package holds:
  - mem_op encodings (MEM_OP_NONE..MEM_OP_SW)
  - FSM state encodings
  - Stop/NoStop
  - ZeroWord
- One sub-module, mem_lane_align: combinational store sel/wdata generation and load extract/extend, shared by the store and load paths.

Test Plan:
- Pass-through: op NONE, ex_wd=5'd3, ex_wdata=32'h1234_5678, ex_whilo=1 -> same-cycle mem_* equal inputs; stallreq=0; bus_cyc_stb stays 0.
- LB sign: addr=0x101, bus_rdata=0x11_F2_33_44, ack after 2 wait cycles -> sel=0100, mem_wdata=0xFFFF_FFF2, stallreq high 3 cycles then low in ack cycle.
- SH lanes: addr=0x202, reg2=0x0000_BEEF -> bus_we=1, sel=0011, wdata=0xBEEF_BEEF, addr=0x200; single transaction.
- HOLD: LW ack while stall[4]=Stop for 3 more cycles -> no re-request; mem_wdata=rdata_q stable; returns to IDLE when stall released.
- Async reset: rst=0 mid-BUSY -> bus_cyc_stb=0 with no clock edge; after release, next LW issues normally.
- With MEM_ALIGN_CHECK_EN, LW addr=0x103 -> addr_err=1, mem_wreg=0, bus_cyc_stb=0, stallreq=0.
